add_share_ctrl: RTL and testbench
=================================

ADD_SHARE_CTRL -- requirements
Module: add_share_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 SHALL have parameter LOA_BITS, default 8, approximate lower-part width when LOA enabled (0..31).
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  32*NREQ  operand A, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_b  input  32*NREQ  operand B, same packing.
REQ-009 SHALL have port req_cin  input  NREQ  carry-in per requester.
REQ-010 SHALL have port res_valid  output  1  result valid.
REQ-011 SHALL have port res_ready  input  1  downstream accepts result.
REQ-012 SHALL have port res_sum  output  32  sum.
REQ-013 SHALL have port res_cout  output  1  carry-out.
REQ-014 SHALL have port res_id  output  $clog2(NREQ)  index of requester that owns the result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
- REQ-016 SHALL implement FSM IDLE -> CALC -> HOLD -> IDLE.
- REQ-017 IDLE: when any req_valid high, SHALL assert req_ready for exactly one requester chosen round-robin, latch its a/b/cin/id, go to CALC in that cycle's edge.
- REQ-018 Round-robin: search SHALL start at (last granted index + 1) mod NREQ; pointer after reset = NREQ-1, so requester 0 wins first.
- REQ-019 req_ready SHALL be combinational from state==IDLE and req_valid; never high outside IDLE; transfer occurs when req_valid&req_ready.
- REQ-020 CALC: one full cycle for the 32-bit ripple chain to settle; at the edge SHALL register sum/cout/id into result registers and go to HOLD.
- REQ-021 HOLD: res_valid=1, outputs stable; on res_valid&res_ready SHALL go to IDLE.
- REQ-022 Latency: grant edge to res_valid high = 2 cycles; max throughput one result per 3 cycles.
- REQ-023 Requester dropping req_valid in a non-IDLE state SHALL have no effect; no request is queued.
- REQ-024 Sum SHALL be A+B+cin modulo 2^32, carry-out in res_cout (exact mode).

Reset
- REQ-025 rst_n low SHALL immediately force state IDLE, req_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, pointer=NREQ-1.
- REQ-026 Reset asserted mid-CALC/HOLD SHALL discard the in-flight operation; nothing is emitted after release.

Configuration
- REQ-027 Macro ADD_SHARE_LOA_EN defined: bits [LOA_BITS-1:0] of res_sum SHALL be a|b (lower-part OR); carry into bit LOA_BITS SHALL be a[LOA_BITS-1]&b[LOA_BITS-1]; req_cin ignored; LOA_BITS=0 equals exact.
- REQ-028 Macro undefined: exact addition per REQ-024; LOA_BITS ignored.

Structure
- REQ-029 Shared package add_share_pkg SHALL hold the FSM state enum (IDLE, CALC, HOLD) and the constant WORD_W=32.
- REQ-030 The adder SHALL be one instance of rca_32bits (exact path); LOA lower part built in the controller.

Verification
- REQ-031 Single: req_valid=0001, a=0x0000_0005, b=0x0000_0003, cin=1 -> req_ready=0001 one cycle, res_valid 2 cycles later, res_sum=0x9, res_cout=0, res_id=0.
- REQ-032 Overflow: a=0xFFFF_FFFF, b=0x1, cin=0 -> res_sum=0x0, res_cout=1.
- REQ-033 Fairness: req_valid=1111 held, res_ready=1 -> grant order 0,1,2,3,0; each result 3 cycles apart.
- REQ-034 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_sum/res_id stable, req_ready=0, no new grant; res_ready=1 -> IDLE next cycle.
- REQ-035 Reset mid-op: rst_n low in CALC -> all outputs 0 immediately; after release, no stale result, next grant goes to requester 0.
- REQ-036 LOA (macro on, LOA_BITS=8): a=0x0000_01FF, b=0x0000_0181 -> res_sum=0x0000_03FF, res_cout=0; macro off -> res_sum=0x0000_0380.

Source files
------------

// File: rtl/add_share_pkg.sv
// Shared types and constants for the time-shared 32-bit adder controller.
package add_share_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Mask covering bits [bits-1:0]; zero when bits is 0.
  function automatic logic [WORD_W-1:0] low_mask(input int bits);
    if (bits <= 0) return '0;
    return {WORD_W{1'b1}} >> (WORD_W - bits);
  endfunction

  // Single bit at position bits-1; zero when bits is 0.
  function automatic logic [WORD_W-1:0] top_bit(input int bits);
    if (bits <= 0) return '0;
    return WORD_W'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/add_share_ctrl_rca_32bits.sv
// Plain 32-bit ripple-carry adder used as the single shared arithmetic resource.
module rca_32bits
  import add_share_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  logic [WORD_W:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[WORD_W];

endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin front end sharing one ripple-carry adder among NREQ requesters.
// Define ADD_SHARE_LOA_EN for a lower-part-OR approximate adder over the low LOA_BITS bits.
module add_share_ctrl
  import add_share_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [WORD_W*NREQ-1:0]   req_a,
  input  logic [WORD_W*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WORD_W-1:0]        res_sum,
  output logic                     res_cout,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

`ifdef ADD_SHARE_LOA_EN
  localparam bit LOA_EN = 1'b1;
`else
  localparam bit LOA_EN = 1'b0;
`endif

  localparam logic [WORD_W-1:0] LOA_MASK = LOA_EN ? low_mask(LOA_BITS) : '0;
  localparam logic [WORD_W-1:0] LOA_TOP  = LOA_EN ? top_bit(LOA_BITS)  : '0;
  localparam bit                USE_CIN  = (LOA_TOP == '0);

  state_e state_q, state_d;

  logic [IDW-1:0]    ptr_q;
  logic [WORD_W-1:0] a_q, b_q;
  logic              cin_q;
  logic [IDW-1:0]    id_q;

  logic [WORD_W-1:0] sum_q;
  logic              cout_q;
  logic [IDW-1:0]    rid_q;

  logic [WORD_W-1:0] a_arr [NREQ];
  logic [WORD_W-1:0] b_arr [NREQ];

  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic              xfer;

  logic              loa_carry;
  logic [WORD_W-1:0] rca_a, rca_b, rca_sum, calc_sum;
  logic              rca_cin, rca_cout;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WORD_W +: WORD_W];
    assign b_arr[i] = req_b[i*WORD_W +: WORD_W];
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign xfer = (state_q == IDLE) && gnt_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_found) state_d = CALC;
      CALC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it drops the moment reset asserts.
  always_comb begin
    req_ready = '0;
    if (rst_n && xfer) req_ready[gnt_idx] = 1'b1;
    res_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_RST;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      id_q  <= '0;
    end else if (xfer) begin
      ptr_q <= gnt_idx;
      a_q   <= a_arr[gnt_idx];
      b_q   <= b_arr[gnt_idx];
      cin_q <= req_cin[gnt_idx];
      id_q  <= gnt_idx;
    end
  end

  // LOA: zero the low part, and plant a[L-1]&b[L-1] on bit L-1 of both operands
  // so the adder's own carry out of that bit becomes the approximate carry-in.
  always_comb begin
    loa_carry = |(a_q & b_q & LOA_TOP);
    rca_a     = (a_q & ~LOA_MASK) | (loa_carry ? LOA_TOP : '0);
    rca_b     = (b_q & ~LOA_MASK) | (loa_carry ? LOA_TOP : '0);
    rca_cin   = USE_CIN ? cin_q : 1'b0;
    calc_sum  = (rca_sum & ~LOA_MASK) | ((a_q | b_q) & LOA_MASK);
  end

  rca_32bits u_rca (
    .a_i    (rca_a),
    .b_i    (rca_b),
    .cin_i  (rca_cin),
    .sum_o  (rca_sum),
    .cout_o (rca_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      rid_q  <= '0;
    end else if (state_q == CALC) begin
      sum_q  <= calc_sum;
      cout_q <= rca_cout;
      rid_q  <= id_q;
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
  assign res_id   = rid_q;

endmodule

// File: tb/tb_add_share_ctrl.sv
// Self-checking bench for add_share_ctrl: directed cases plus randomized transactions
// checked against a transaction-level arithmetic and round-robin model.
module tb_add_share_ctrl;

  localparam int NREQ     = 4;
  localparam int LOA_BITS = 8;
  localparam int W        = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic [1:0]        res_id;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int rr_ptr = NREQ - 1;
  int cyc    = 0;
  int rv_cyc = 0;
  int rv_id  = 0;

  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];
  logic         op_c [NREQ];

  add_share_ctrl #(.NREQ(NREQ), .LOA_BITS(LOA_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_cin[i]      = op_c[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_c[i] = 1'($urandom_range(0, 1));
    end
    drive_ops();
  endtask

  // {cout, sum} as the arithmetic rules define it, using wide integer math.
  function automatic logic [32:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
    longint unsigned la, lb, lo, hi, cc, r;
    la = longint'(a);
    lb = longint'(b);
`ifdef ADD_SHARE_LOA_EN
    if (LOA_BITS > 0) begin
      lo = (la | lb) & ((64'd1 << LOA_BITS) - 64'd1);
      cc = (la >> (LOA_BITS - 1)) & (lb >> (LOA_BITS - 1)) & 64'd1;
      hi = (la >> LOA_BITS) + (lb >> LOA_BITS) + cc;
      r  = (hi << LOA_BITS) | lo;
      return r[32:0];
    end
`endif
    lo = 0;
    hi = 0;
    cc = c ? 64'd1 : 64'd0;
    r  = la + lb + cc;
    return r[32:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_sum"},   res_sum,   0);
    chk({tag, "_res_cout"},  res_cout,  0);
    chk({tag, "_res_id"},    res_id,    0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // One request/response exchange, entered and left just after a falling edge in IDLE.
  task automatic txn(input logic [NREQ-1:0] vmask, input int hold, input bit drop);
    logic [32:0]     es;
    logic [NREQ-1:0] exp_rdy;
    int              g;
    req_valid = vmask;
    res_ready = (hold == 0);
    #1;
    g       = pick(vmask);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("grant", req_ready, exp_rdy);
    chk("idle_busy", busy, 0);
    if (g < 0) begin
      @(negedge clk); #1;
      chk("no_req_stays_idle", busy, 0);
      return;
    end
    rr_ptr = g;
    es     = model_add(op_a[g], op_b[g], op_c[g]);
    @(negedge clk); #1;
    chk("calc_busy", busy, 1);
    chk("calc_ready", req_ready, 0);
    chk("calc_res_valid", res_valid, 0);
    if (drop) req_valid = '0;
    @(negedge clk); #1;
    rv_cyc = cyc;
    rv_id  = int'(res_id);
    chk("hold_res_valid", res_valid, 1);
    chk("sum", res_sum, es[31:0]);
    chk("cout", res_cout, es[32]);
    chk("id", res_id, g);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk); #1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_sum", res_sum, es[31:0]);
      chk("bp_id", res_id, g);
      chk("bp_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    chk("back_idle_busy", busy, 0);
    chk("back_idle_res_valid", res_valid, 0);
  endtask

  initial begin
    int prev_cyc;
    rst_n     = 1'b0;
    res_ready = 1'b0;
    req_valid = '1;
    rand_ops();
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single transfer on requester 0.
    op_a[0] = 32'h0000_0005; op_b[0] = 32'h0000_0003; op_c[0] = 1'b1;
    drive_ops();
    txn(4'b0001, 0, 0);

    // Overflow on requester 1.
    op_a[1] = 32'hFFFF_FFFF; op_b[1] = 32'h0000_0001; op_c[1] = 1'b0;
    drive_ops();
    txn(4'b0010, 0, 0);

    // Lower-part OR vector on requester 2.
    op_a[2] = 32'h0000_01FF; op_b[2] = 32'h0000_0181; op_c[2] = 1'b0;
    drive_ops();
    txn(4'b0100, 0, 0);
`ifdef ADD_SHARE_LOA_EN
    chk("loa_vector_sum", res_sum, 32'h0000_03FF);
`else
    chk("loa_vector_sum", res_sum, 32'h0000_0380);
`endif
    chk("loa_vector_cout", res_cout, 0);

    // Reset while in CALC: in-flight operation discarded, pointer restarts.
    req_valid = 4'b0100;
    #1;
    chk("pre_reset_grant", req_ready, 4'b0100);
    @(negedge clk); #1;
    chk("pre_reset_calc", busy, 1);
    req_valid = '1;
    rst_n     = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    rr_ptr = NREQ - 1;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_reset_no_stale", res_valid, 0);
    end

    // Fairness with all requesters held valid.
    rand_ops();
    prev_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 0, 0);
      chk("fair_order", rv_id, i % NREQ);
      if (i > 0) chk("fair_spacing", rv_cyc - prev_cyc, 3);
      prev_cyc = rv_cyc;
    end

    // Backpressure for five cycles in HOLD.
    rand_ops();
    txn(4'b1111, 5, 0);

    // Requester withdraws during CALC.
    rand_ops();
    txn(4'b1000, 0, 1);

    for (int n = 0; n < 25; n++) begin
      rand_ops();
      txn(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    req_valid = '0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
